// File: rtl/multicore_pkg.sv
// Shared types and sizes for the core pipeline.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: datapath widths, memory-access size/state enums, memtoreg encodings,
// the MA stage-register bundle and the shared alignment check.
package multicore_pkg;

  localparam int DATA_SIZE  = 32;
  localparam int ADDR_SIZE  = 32;
  localparam int INST_SIZE  = 32;
  localparam int NUM_REGS   = 32;
  localparam int RDEST_SIZE = $clog2(NUM_REGS);

  typedef enum logic [1:0] {
    MEM_BYTE = 2'b00,
    MEM_HALF = 2'b01,
    MEM_WORD = 2'b10
  } t_memsize;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    WAIT   = 2'b10
  } t_ma_state;

  localparam logic [1:0] MEMTOREG_ALU = 2'b00;
  localparam logic [1:0] MEMTOREG_MEM = 2'b01;
  localparam logic [1:0] MEMTOREG_PC  = 2'b10;

  // Everything the MA stage keeps from the EX bundle.
  typedef struct packed {
    logic [DATA_SIZE-1:0]  calc;
    logic [DATA_SIZE-1:0]  wdata;
    logic [INST_SIZE-1:0]  pcplus4;
    logic [RDEST_SIZE-1:0] rdest;
    logic                  regwrite;
    logic                  memwrite;
    logic [1:0]            memtoreg;
    t_memsize              memsize;
    logic                  mem_unsigned;
  } t_ma_stage;

  // Used both on the incoming bundle (to decide whether to start an access)
  // and on the stage register (to raise the misaligned flag), so the two
  // views can never disagree.
  function automatic logic is_misaligned(input logic [1:0] addr_lo, input t_memsize size);
    case (size)
      MEM_HALF: return addr_lo[0];
      MEM_WORD: return |addr_lo;
      default:  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Sub-word lane handling for data-memory accesses: byte enables, store lane
// replication, load extraction with sign/zero extension, misalignment detect.
// Latency: purely combinational. Backpressure: none (no state).
// Ports: addr_lo/memsize/mem_unsigned describe the access; store_data and
// load_data are the raw lanes; byte_en/store_rep/load_ext/misaligned are results.
module lsu_align
  import multicore_pkg::*;
(
  input  logic [1:0]           addr_lo,
  input  t_memsize             memsize,
  input  logic                 mem_unsigned,
  input  logic [DATA_SIZE-1:0] store_data,
  input  logic [DATA_SIZE-1:0] load_data,
  output logic [3:0]           byte_en,
  output logic [DATA_SIZE-1:0] store_rep,
  output logic [DATA_SIZE-1:0] load_ext,
  output logic                 misaligned
);

  logic [DATA_SIZE-1:0] shifted;

  // Bring the addressed byte/half down to lane 0 before extension.
  assign shifted    = load_data >> {addr_lo, 3'b000};
  assign misaligned = is_misaligned(addr_lo, memsize);

  always_comb begin
    byte_en   = 4'b1111;
    store_rep = store_data;
    load_ext  = shifted;
    case (memsize)
      MEM_BYTE: begin
        byte_en   = 4'b0001 << addr_lo;
        store_rep = {4{store_data[7:0]}};
        load_ext  = {{24{~mem_unsigned & shifted[7]}}, shifted[7:0]};
      end
      MEM_HALF: begin
        byte_en   = 4'b0011 << addr_lo;
        store_rep = {2{store_data[15:0]}};
        load_ext  = {{16{~mem_unsigned & shifted[15]}}, shifted[15:0]};
      end
      default: begin
        byte_en   = 4'b1111;
        store_rep = store_data;
        load_ext  = shifted;
      end
    endcase
  end

endmodule

// File: rtl/memory_access_unit.sv
// MA pipeline stage: runs the load/store described by the EX bundle over a
// req/gnt/rvalid port and hands the result to WB. Latency: 1 cycle for ALU ops
// and stores granted at once, >=2 for loads. Backpressure: o_stall holds EX.
// Ports: i_aclk/i_areset_n; i_en + i_exe_*/i_pcplus4/i_rdest/i_cu_* = EX bundle;
// o_dmem_*/i_dmem_* = data memory; o_ma_fwd to EX; o_wb_data/o_rdest/
// o_cu_regwrite to WB; o_misaligned flags a rejected sub-word access.
module memory_access_unit
  import multicore_pkg::*;
(
  input  logic                  i_aclk,
  input  logic                  i_areset_n,
  input  logic                  i_en,
  input  logic [DATA_SIZE-1:0]  i_exe_calc,
  input  logic [DATA_SIZE-1:0]  i_exe_wdata,
  input  logic [INST_SIZE-1:0]  i_pcplus4,
  input  logic [RDEST_SIZE-1:0] i_rdest,
  input  logic                  i_cu_regwrite,
  input  logic                  i_cu_memwrite,
  input  logic [1:0]            i_cu_memtoreg,
  input  t_memsize              i_cu_memsize,
  input  logic                  i_cu_mem_unsigned,
  output logic                  o_stall,
  output logic                  o_dmem_req,
  output logic                  o_dmem_we,
  output logic [ADDR_SIZE-1:0]  o_dmem_addr,
  output logic [DATA_SIZE-1:0]  o_dmem_wdata,
  output logic [3:0]            o_dmem_be,
  input  logic                  i_dmem_gnt,
  input  logic                  i_dmem_rvalid,
  input  logic [DATA_SIZE-1:0]  i_dmem_rdata,
  output logic [DATA_SIZE-1:0]  o_ma_fwd,
  output logic [DATA_SIZE-1:0]  o_wb_data,
  output logic [RDEST_SIZE-1:0] o_rdest,
  output logic                  o_cu_regwrite,
  output logic                  o_misaligned
);

  t_ma_stage            stg;
  t_ma_state            state;
  logic                 stg_load;
  logic                 stg_store;
  logic                 align_err;
  logic [DATA_SIZE-1:0] load_ext;
  logic [DATA_SIZE-1:0] wb_next;
  logic                 start_access;

  // ---------------------------------------------------------------------------
  // Stage register: only advances when the stage is not busy.
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_aclk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      stg <= '0;
    end else if (!o_stall) begin
      if (i_en) begin
        stg.calc         <= i_exe_calc;
        stg.wdata        <= i_exe_wdata;
        stg.pcplus4      <= i_pcplus4;
        stg.rdest        <= i_rdest;
        stg.regwrite     <= i_cu_regwrite;
        stg.memwrite     <= i_cu_memwrite;
        stg.memtoreg     <= i_cu_memtoreg;
        stg.memsize      <= i_cu_memsize;
        stg.mem_unsigned <= i_cu_mem_unsigned;
      end else begin
        stg <= '0;
      end
    end
  end

  assign stg_load  = (stg.memtoreg == MEMTOREG_MEM);
  assign stg_store = stg.memwrite;

  // The access decision is taken on the incoming bundle so the request can be
  // raised in the very first MA cycle; misaligned ops never leave IDLE.
  assign start_access = i_en
                      & (i_cu_memwrite | (i_cu_memtoreg == MEMTOREG_MEM))
                      & ~is_misaligned(i_exe_calc[1:0], i_cu_memsize);

  // ---------------------------------------------------------------------------
  // Access FSM. A completing access (stall low) is also a capture edge, so a
  // back-to-back memory op goes straight from ACCESS/WAIT to ACCESS.
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_aclk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      state <= IDLE;
    end else if (!o_stall) begin
      state <= start_access ? ACCESS : IDLE;
    end else if (state == ACCESS && i_dmem_gnt) begin
      // Only a load can be stalled with gnt high; wait for its data.
      state <= WAIT;
    end
  end

  assign o_stall = ((state == ACCESS) & ~(stg_store & i_dmem_gnt))
                 | ((state == WAIT)   & ~i_dmem_rvalid);

  // Request fields come straight from the stage register, which is frozen
  // while stalled, so they stay stable until gnt.
  assign o_dmem_req  = (state == ACCESS);
  assign o_dmem_we   = stg_store;
  assign o_dmem_addr = {stg.calc[ADDR_SIZE-1:2], 2'b00};

  lsu_align u_lsu_align (
    .addr_lo      (stg.calc[1:0]),
    .memsize      (stg.memsize),
    .mem_unsigned (stg.mem_unsigned),
    .store_data   (stg.wdata),
    .load_data    (i_dmem_rdata),
    .byte_en      (o_dmem_be),
    .store_rep    (o_dmem_wdata),
    .load_ext     (load_ext),
    .misaligned   (align_err)
  );

  // Only meaningful for memory ops; a bubble or ALU op never flags.
  assign o_misaligned = (stg_load | stg_store) & align_err;

  assign o_ma_fwd = (stg.memtoreg == MEMTOREG_PC) ? DATA_SIZE'(stg.pcplus4) : stg.calc;
  assign wb_next  = stg_load ? load_ext : o_ma_fwd;

  // ---------------------------------------------------------------------------
  // WB register: a stalled cycle hands WB a bubble.
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_aclk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      o_wb_data     <= '0;
      o_rdest       <= '0;
      o_cu_regwrite <= 1'b0;
    end else if (o_stall) begin
      o_cu_regwrite <= 1'b0;
    end else begin
      o_wb_data     <= wb_next;
      o_rdest       <= stg.rdest;
      o_cu_regwrite <= stg.regwrite & ~o_misaligned;
    end
  end

endmodule
